// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared constants and elaboration-time helpers for the serial pattern
// detector. The detector never stores a hand-written transition table;
// instead buildTable() derives every next-state entry from the target
// pattern using the matched-prefix (KMP) rule.
//
// Contents:
//   DEF_PAT_W / DEF_PATTERN  default pattern length and value
//   MAX_PAT_W                largest supported pattern length
//   ST_W / TBL_W             width of one table entry and of the whole table
//   borderLen()              longest proper border of the pattern
//   nextState()              matched-prefix length after one more bit
//   buildTable()             packed next-state table for every state/bit
// ---------------------------------------------------------------------------
package seq_det_pkg;

    localparam int DEF_PAT_W = 3;
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 3'b101;
    localparam int MAX_PAT_W = 16;
    localparam int ST_W = 5;
    localparam int TBL_W = (MAX_PAT_W + 1) * 2 * ST_W;

    // Bit i of the pattern counted from the first-received bit (the MSB).
    function automatic logic patBit(input logic [15:0] pat, input int patW, input int i);
        logic [15:0] t;
        t = pat >> (patW - 1 - i);
        return t[0];
    endfunction

    // Longest proper prefix of the pattern that is also a suffix of it.
    function automatic int borderLen(input logic [15:0] pat, input int patW);
        int  best;
        logic ok;
        best = 0;
        for (int j = 1; j < patW; j++) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
                if (patBit(pat, patW, i) != patBit(pat, patW, patW - j + i)) ok = 1'b0;
            end
            if (ok) best = j;
        end
        return best;
    endfunction

    // From a state holding k matched bits, the received text is the first
    // k pattern bits followed by xBit. The new state is the longest suffix
    // of that text which is also a prefix of the pattern.
    function automatic int nextState(input logic [15:0] pat, input int patW,
                                     input int k, input logic xBit);
        int   best;
        int   pos;
        logic ok;
        logic textBit;
        best = 0;
        for (int j = 1; j <= k + 1; j++) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
                pos = k + 1 - j + i;
                textBit = (pos == k) ? xBit : patBit(pat, patW, pos);
                if (textBit != patBit(pat, patW, i)) ok = 1'b0;
            end
            if (ok) best = j;
        end
        return best;
    endfunction

    // Entry (k*2 + x) holds the next state from state k on input bit x.
    // The accept state first steps back to the border (overlapping) or to
    // zero (non-overlapping) and then consumes the bit from there.
    function automatic logic [TBL_W-1:0] buildTable(input logic [15:0] pat, input int patW,
                                                    input logic overlap);
        logic [TBL_W-1:0] tbl;
        int from;
        int ns;
        tbl = '0;
        for (int k = 0; k <= patW; k++) begin
            for (int b = 0; b < 2; b++) begin
                if (k == patW) from = overlap ? borderLen(pat, patW) : 0;
                else           from = k;
                ns  = nextState(pat, patW, from, (b != 0));
                tbl = tbl | (TBL_W'(ns) << ((k * 2 + b) * ST_W));
            end
        end
        return tbl;
    endfunction

endpackage

// File: rtl/seq_pattern_detector_if.sv
// ---------------------------------------------------------------------------
// seq_pattern_detector_if
// Bundles the serial input and the detector status outputs.
//   en, x, clr_cnt       bit-valid, serial bit, synchronous counter clear
//   y                    match flag (accept state)
//   prefix_len           current matched-prefix length
//   match_cnt, cnt_sat   saturating match count and its saturation flag
// master: the side that feeds bits and reads status.
// slave : the detector.
// ---------------------------------------------------------------------------
interface seq_pattern_detector_if
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = 8
);

    localparam int SW = $clog2(PAT_W + 1);

    logic             en;
    logic             x;
    logic             clr_cnt;
    logic             y;
    logic [SW-1:0]    prefix_len;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    modport master (
        output en, x, clr_cnt,
        input  y, prefix_len, match_cnt, cnt_sat
    );

    modport slave (
        input  en, x, clr_cnt,
        output y, prefix_len, match_cnt, cnt_sat
    );

endinterface

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones, with a synchronous clear that wins
// over an increment on the same edge.
//   clk  clock            rst  asynchronous active-high reset
//   inc  count request    clr  synchronous clear
//   cnt  count value      sat  registered "cnt is all-ones" flag
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    // Next count: clear first, otherwise step unless already at the top.
    // The saturation flag is computed from the next count so it is
    // registered in the same edge as the count itself.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !sat_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        sat_d = &cnt_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = sat_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// ---------------------------------------------------------------------------
// seq_pattern_detector
// Moore FSM that watches a serial bit stream for PATTERN (MSB first).
// The state is the matched-prefix length 0..PAT_W; PAT_W is the accept
// state and drives y. Transitions come from a table generated at
// elaboration by seq_det_pkg::buildTable.
//   clk  clock                rst  asynchronous active-high reset
//   bus  slave side of seq_pattern_detector_if (en, x, clr_cnt in;
//        y, prefix_len, match_cnt, cnt_sat out)
// ---------------------------------------------------------------------------
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
    parameter int               OVERLAP = 1,
    parameter int               CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_pattern_detector_if.slave bus
);

    localparam int               SW       = $clog2(PAT_W + 1);
    localparam logic [SW-1:0]    ACCEPT   = SW'(PAT_W);
    localparam logic [TBL_W-1:0] NEXT_TBL = buildTable(16'(PATTERN), PAT_W, (OVERLAP != 0));

    logic [SW-1:0] state_q, state_d;
    logic [8:0]    tblShift;
    logic          matchNext;

    // Next state is a lookup of the entry for (state, x). States above
    // PAT_W cannot be reached, but their entries are zero so any stray
    // value returns to S0 on the next valid bit.
    always_comb begin
        state_d   = state_q;
        tblShift  = 9'({state_q, bus.x}) * 9'(ST_W);
        if (bus.en) begin
            state_d = SW'(NEXT_TBL >> tblShift);
        end
        matchNext = bus.en && (state_d == ACCEPT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.y          = (state_q == ACCEPT);
    assign bus.prefix_len = state_q;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (matchNext),
        .clr (bus.clr_cnt),
        .cnt (bus.match_cnt),
        .sat (bus.cnt_sat)
    );

endmodule

// File: tb/tb_seq_pattern_detector.sv
// ---------------------------------------------------------------------------
// tb_seq_pattern_detector
// Four detector configurations share one input stream:
//   dut0  101, overlapping, 8-bit count
//   dut1  101, non-overlapping, 8-bit count
//   dut2  1101, overlapping, 8-bit count
//   dut3  101, overlapping, 2-bit count
// A reference model keeps the recent accepted bits per configuration and
// finds the longest suffix that is a pattern prefix.
// ---------------------------------------------------------------------------
module tb_seq_pattern_detector;

    logic clk;
    logic rst;
    logic en;
    logic x;
    logic clr;

    int vectors;
    int miscompares;

    seq_pattern_detector_if #(.PAT_W(3), .CNT_W(8)) bus0 ();
    seq_pattern_detector_if #(.PAT_W(3), .CNT_W(8)) bus1 ();
    seq_pattern_detector_if #(.PAT_W(4), .CNT_W(8)) bus2 ();
    seq_pattern_detector_if #(.PAT_W(3), .CNT_W(2)) bus3 ();

    assign bus0.en = en;  assign bus0.x = x;  assign bus0.clr_cnt = clr;
    assign bus1.en = en;  assign bus1.x = x;  assign bus1.clr_cnt = clr;
    assign bus2.en = en;  assign bus2.x = x;  assign bus2.clr_cnt = clr;
    assign bus3.en = en;  assign bus3.x = x;  assign bus3.clr_cnt = clr;

    seq_pattern_detector #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1), .CNT_W(8))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    seq_pattern_detector #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(0), .CNT_W(8))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    seq_pattern_detector #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1), .CNT_W(8))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));
    seq_pattern_detector #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1), .CNT_W(2))
        dut3 (.clk(clk), .rst(rst), .bus(bus3));

    int obsY[4];
    int obsPre[4];
    int obsCnt[4];
    int obsSat[4];

    assign obsY[0] = int'(bus0.y);  assign obsPre[0] = int'(bus0.prefix_len);
    assign obsY[1] = int'(bus1.y);  assign obsPre[1] = int'(bus1.prefix_len);
    assign obsY[2] = int'(bus2.y);  assign obsPre[2] = int'(bus2.prefix_len);
    assign obsY[3] = int'(bus3.y);  assign obsPre[3] = int'(bus3.prefix_len);
    assign obsCnt[0] = int'(bus0.match_cnt);  assign obsSat[0] = int'(bus0.cnt_sat);
    assign obsCnt[1] = int'(bus1.match_cnt);  assign obsSat[1] = int'(bus1.cnt_sat);
    assign obsCnt[2] = int'(bus2.match_cnt);  assign obsSat[2] = int'(bus2.cnt_sat);
    assign obsCnt[3] = int'(bus3.match_cnt);  assign obsSat[3] = int'(bus3.cnt_sat);

    // Per-configuration parameters seen by the model.
    int          cfgPw[4]  = '{3, 3, 4, 3};
    logic [15:0] cfgPat[4] = '{16'b101, 16'b101, 16'b1101, 16'b101};
    int          cfgOv[4]  = '{1, 0, 1, 1};
    int          cfgMax[4] = '{255, 255, 255, 3};

    // Model state: recent accepted bits (newest in bit 0) and expectations.
    logic [15:0] hist[4];
    int          histLen[4];
    int          expState[4];
    int          expCnt[4];

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic bitAt(input logic [15:0] v, input int i);
        logic [15:0] t;
        t = v >> i;
        return t[0];
    endfunction

    // Longest suffix of the accepted bits that equals a prefix of the pattern.
    function automatic int longestSuffix(input logic [15:0] h, input int len,
                                         input logic [15:0] pat, input int pw);
        int   best;
        logic ok;
        best = 0;
        for (int j = 1; j <= pw; j++) begin
            if (j <= len) begin
                ok = 1'b1;
                for (int i = 0; i < j; i++) begin
                    if (bitAt(h, j - 1 - i) != bitAt(pat, pw - 1 - i)) ok = 1'b0;
                end
                if (ok) best = j;
            end
        end
        return best;
    endfunction

    // Resetting the model forgets every partial match and count.
    task automatic modelReset();
        for (int d = 0; d < 4; d++) begin
            hist[d]     = '0;
            histLen[d]  = 0;
            expState[d] = 0;
            expCnt[d]   = 0;
        end
    endtask

    // One clock edge of the model. A non-overlapping detector forgets the
    // bits of a completed match so the next search starts from scratch.
    task automatic modelStep(input logic e, input logic xb, input logic c);
        int s;
        for (int d = 0; d < 4; d++) begin
            if (e) begin
                hist[d]    = {hist[d][14:0], xb};
                histLen[d] = (histLen[d] < 16) ? histLen[d] + 1 : 16;
                s = longestSuffix(hist[d], histLen[d], cfgPat[d], cfgPw[d]);
                expState[d] = s;
                if (s == cfgPw[d]) begin
                    if (expCnt[d] < cfgMax[d]) expCnt[d] = expCnt[d] + 1;
                    if (cfgOv[d] == 0) histLen[d] = 0;
                end
            end
            if (c) expCnt[d] = 0;
        end
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkAll();
        for (int d = 0; d < 4; d++) begin
            checkOutput($sformatf("dut%0d.y", d), obsY[d], (expState[d] == cfgPw[d]) ? 1 : 0);
            checkOutput($sformatf("dut%0d.prefix_len", d), obsPre[d], expState[d]);
            checkOutput($sformatf("dut%0d.match_cnt", d), obsCnt[d], expCnt[d]);
            checkOutput($sformatf("dut%0d.cnt_sat", d), obsSat[d], (expCnt[d] == cfgMax[d]) ? 1 : 0);
        end
    endtask

    // Drive inputs on the falling edge, advance the model on the rising
    // edge and compare shortly after it.
    task automatic applyStimulus(input logic e, input logic xb, input logic c);
        @(negedge clk);
        en  = e;
        x   = xb;
        clr = c;
        @(posedge clk);
        modelStep(e, xb, c);
        #1;
        checkAll();
    endtask

    // Reset pulse placed between clock edges; outputs must clear before
    // the next rising edge arrives.
    task automatic pulseReset();
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkAll();
        rst = 1'b0;
    endtask

    initial begin
        logic s1[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic s2[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        int   pre2[5] = '{1, 2, 2, 3, 4};

        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        en  = 1'b0;
        x   = 1'b0;
        clr = 1'b0;
        modelReset();
        #1;
        checkAll();
        @(negedge clk);
        rst = 1'b0;

        // 1,0,1,0,1: two overlapping matches, one non-overlapping match.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, s1[i], 1'b0);
        checkOutput("ovl_cnt", obsCnt[0], 2);
        checkOutput("novl_cnt", obsCnt[1], 1);
        checkOutput("novl_y", obsY[1], 0);

        // 1,1,1,0,1 against 1101 walks the prefix through the fallback.
        pulseReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, s2[i], 1'b0);
            checkOutput($sformatf("p1101_pre%0d", i), obsPre[2], pre2[i]);
        end
        checkOutput("p1101_y", obsY[2], 1);

        // Bits with en low must be ignored.
        pulseReset();
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, (i % 2 == 0), 1'b0);
            checkOutput("gap_pre", obsPre[0], 1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("gap_y", obsY[0], 1);
        checkOutput("gap_cnt", obsCnt[0], 1);

        // Saturate the 2-bit counter, then clear it on the edge of a match.
        pulseReset();
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, (i % 2 == 0), 1'b0);
        checkOutput("sat_cnt", obsCnt[3], 3);
        checkOutput("sat_flag", obsSat[3], 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("clr_cnt", obsCnt[3], 0);
        checkOutput("clr_sat", obsSat[3], 0);
        checkOutput("clr_y", obsY[3], 1);

        // Reset in the middle of a pattern and again while matched.
        pulseReset();
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("mid_pre", obsPre[0], 2);
        pulseReset();
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("acc_y", obsY[0], 1);
        pulseReset();

        // Random traffic with occasional clears and asynchronous resets.
        for (int n = 0; n < 800; n++) begin
            if ($urandom % 97 == 0) pulseReset();
            applyStimulus(($urandom % 4) != 0, ($urandom % 2) != 0, ($urandom % 40) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_pattern_detector.md
SEQ_PATTERN_DETECTOR -- requirements
Module: seq_pattern_detector

Interface
REQ-001 Parameter PAT_W, default 3: pattern length in bits; legal range 2..16.
REQ-002 Parameter PATTERN, default 3'b101: PAT_W-bit target sequence; MSB is the first bit received.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping matches; 0 = restart after each match.
REQ-004 Parameter CNT_W, default 8: width of the match counter.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 en  in  1  bit-valid; x is sampled only when en=1.
REQ-008 x  in  1  serial data bit.
REQ-009 clr_cnt  in  1  synchronous clear of match_cnt and cnt_sat.
REQ-010 y  out  1  Moore match flag, 1 while the FSM is in the accept state.
REQ-011 prefix_len  out  $clog2(PAT_W+1)  current matched-prefix length (state register).
REQ-012 match_cnt  out  CNT_W  saturating count of matches.
REQ-013 cnt_sat  out  1  1 when match_cnt = all-ones.

Function
REQ-014 The FSM SHALL have PAT_W+1 states S0..S(PAT_W); state Sk means the last k accepted bits equal the first k bits of PATTERN; S(PAT_W) is the accept state.
REQ-015 y SHALL be a pure decode of the state register (y = state==S(PAT_W)), with no combinational path from x or en.
REQ-016 Latency: y SHALL rise in the cycle immediately after the clock edge that samples the final pattern bit.
REQ-017 From Sk with k<PAT_W, en=1, and x = PATTERN[PAT_W-1-k], the next state SHALL be S(k+1).
REQ-018 From Sk with k<PAT_W, en=1, and a mismatching x, the next state SHALL be the longest j≤k such that the last j received bits (including x) equal PATTERN's first j bits (KMP fallback).
REQ-019 From S(PAT_W) with en=1: if OVERLAP=1, evaluate x as if from Sf, where f is the longest proper border of PATTERN; if OVERLAP=0, evaluate x as if from S0.
REQ-020 When en=0, state, y and match_cnt SHALL hold.
REQ-021 The fallback/border table SHALL be computed at elaboration from PATTERN, not hand-coded per pattern.
REQ-022 match_cnt SHALL increment by 1 on every edge where en=1 and the next state is S(PAT_W), including accept-to-accept transitions.
REQ-023 match_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-024 cnt_sat SHALL be registered with match_cnt and SHALL track the saturation condition.
REQ-025 clr_cnt=1 SHALL clear match_cnt and cnt_sat on the next edge; if a match occurs on the same edge, clear wins and the count is 0.
REQ-026 clr_cnt SHALL NOT affect the FSM state.

Reset
REQ-027 rst=1 SHALL immediately force state=S0, y=0, prefix_len=0, match_cnt=0 and cnt_sat=0, independent of clk.
REQ-028 Assertion of rst in any state, including mid-pattern or in accept, SHALL discard the partial match; after release, detection restarts from S0 on the first rising edge with en=1.

Structure
REQ-029 Package seq_det_pkg SHALL hold the default PATTERN/PAT_W constants and the elaboration-time function that computes the border/next-state table.
REQ-030 The saturating counter with clear SHALL be a sub-module, sat_counter (parameter CNT_W; ports clk, rst, inc, clr, cnt, sat).

Verification
REQ-031 Defaults, OVERLAP=1, en=1, x=1,0,1,0,1 -> y=1 in the cycles after bit 3 and after bit 5; match_cnt=2.
REQ-032 Same stream, OVERLAP=0 -> y=1 only after bit 3; match_cnt=1.
REQ-033 PATTERN=4'b1101, x=1,1,1,0,1 -> prefix_len = 1,2,2,3,4; y=1 after bit 5.
REQ-034 Defaults, x=1, then en=0 for 3 cycles with x toggling, then x=0,1 -> no state change during the gap; y=1 after the final bit; match_cnt=1.
REQ-035 CNT_W=2, 4 matches -> match_cnt=3 and cnt_sat=1; then clr_cnt=1 coincident with a 5th match -> match_cnt=0 and cnt_sat=0.
REQ-036 rst pulsed asynchronously between clock edges while in S2, and again while y=1 -> y, prefix_len and match_cnt go to 0 before the next edge.
